cpu_bus_adapter: RTL
====================

// Module: cpu_bus_adapter
// PURPOSE
//  Upstream feeder of the bus master port: turns one OpenMIPS MEM-stage (or IF-stage) load/store
//  request into one bus transaction and stalls the pipeline until the bus ack arrives.
//  Holds read data across pipeline stalls and aborts cleanly on an exception flush.
//  Sits between the CPU core and the bus master port (m_addr/m_data/m_we/m_select/m_ack).
// PARAMETERS
//  SEL_W          16   bus select width; [3:0]=byte lanes, [SEL_W-1:4] driven 0
//  TIMEOUT_CYCLES 255  cycles in BUSY before abort (used only with BUS_TIMEOUT_EN)
// PORTS
//  clk_i         in   1      clock; sole clock domain
//  rst_i         in   1      synchronous reset, active-high
//  cpu_req_i     in   1      level: access requested while high
//  cpu_we_i      in   1      1=store, 0=load
//  cpu_addr_i    in   32     byte address
//  cpu_wdata_i   in   32     store data
//  cpu_sel_i     in   4      byte-lane enables
//  stall_i       in   6      pipeline stall vector; bit[3] (MEM) is used
//  flush_i       in   1      exception flush: abort current access
//  cpu_rdata_o   out  32     load data, valid in DONE
//  cpu_stall_o   out  1      stall request to ctrl
//  bus_err_o     out  1      1-cycle pulse on timeout abort
//  bus_addr_o    out  32     to bus m_addr_i
//  bus_data_o    out  32     to bus m_data_i
//  bus_we_o      out  1      to bus m_we_i
//  bus_select_o  out  SEL_W  to bus m_select_i; all-zero = no transaction
//  bus_data_i    in   32     from bus m_data_o
//  bus_ack_i     in   1      from bus m_ack_o
// BEHAVIOUR
//  Reset (sync, rst_i=1 at a clk_i edge): state=IDLE, every output 0.
//  States IDLE -> BUSY -> DONE -> IDLE. Bus outputs are registered; cpu_stall_o is combinational.
//  IDLE: when cpu_req_i && !flush_i, register addr/wdata/we/sel and go BUSY. Drive the bus
//   outputs from the next cycle. cpu_stall_o=cpu_req_i in the same cycle as the request.
//   cpu_sel_i==0 is treated as 4'hF.
//  BUSY: hold every bus output stable. cpu_stall_o=1. Wait for bus_ack_i.
//   Ack: register bus_data_i into cpu_rdata_o (loads only; stores leave it unchanged).
//   Same edge: bus_select_o<=0, bus_we_o<=0, go DONE. Ack is honoured in the first BUSY cycle.
//  DONE: cpu_stall_o=0. cpu_rdata_o is held. If stall_i[3]=1, remain in DONE and ignore cpu_req_i.
//   Otherwise go IDLE. A new request is accepted from IDLE only, so back-to-back accesses
//   are spaced by at least 1 idle cycle.
//  flush_i: in any state, go IDLE next cycle and clear bus_select_o/bus_we_o.
//   cpu_stall_o=0 in the flush cycle. An ack in the same cycle as the flush is discarded.
//   cpu_rdata_o is not updated.
//  bus_ack_i seen in IDLE/DONE: ignored, no state change.
//  Reset mid-BUSY: state and outputs go to reset values at that edge. A late ack is ignored.
//  Latency: request cycle T; bus driven T+1; ack at T+k; rdata valid and stall low at T+k+1.
//  The adapter never issues a second transaction while one is outstanding.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: counter clears on entry to BUSY and increments each BUSY cycle.
//   When it reaches TIMEOUT_CYCLES without an ack: abort the bus (select=0), set cpu_rdata_o=0,
//   pulse bus_err_o for 1 cycle and go DONE.
//  BUS_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; bus_err_o tied 0.
//   The port list is identical either way.
// STRUCTURE
//  defines.v: RegBus width, state encodings AdpIdle/AdpBusy/AdpDone.
//   Also the stall bit index StallMem=3 and the error read value ZeroWord.
//  One sub-module, bus_timeout_cnt (clear, enable, expired), instantiated only under BUS_TIMEOUT_EN.
// TESTING
//  Load: req, we=0, addr=32'h0000_1004, sel=4'hF. Ack after 3 cycles with data 32'hCAFE_0123.
//   -> select 16'h000F for 3 cycles; rdata=32'hCAFE_0123; stall low exactly 1 cycle after ack.
//  Store: we=1, addr=32'h10, wdata=32'h55AA_55AA, sel=4'b0011, ack in first BUSY cycle.
//   -> bus_data_o=32'h55AA_55AA, bus_we_o=1, select=16'h0003 for 1 cycle; rdata unchanged.
//  Stall hold: ack while stall_i[3]=1 held 4 cycles -> stays DONE, rdata stable, no new bus cycle.
//  Flush: flush_i in 2nd BUSY cycle with ack in the same cycle.
//   -> IDLE next cycle, select=0, rdata not updated.
//  Reset mid-BUSY: rst_i=1 during BUSY -> all outputs 0 next edge; ack 2 cycles later is ignored.
//  Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8): no ack.
//   -> abort after 8 BUSY cycles, bus_err_o pulses once, rdata=0, stall drops.

Source files
------------

// File: rtl/cpu_bus_adapter_pkg.sv
// Shared types and constants for the CPU-to-bus load/store adapter.
package cpu_bus_adapter_pkg;

    localparam int REG_BUS   = 32;
    localparam int STALL_MEM = 3;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ADP_IDLE = 2'd0,
        ADP_BUSY = 2'd1,
        ADP_DONE = 2'd2
    } adp_state_e;

    // A request with no lanes selected is a full-word access.
    function automatic logic [3:0] norm_sel(input logic [3:0] sel);
        return (sel == 4'h0) ? 4'hF : sel;
    endfunction

endpackage

// File: rtl/cpu_bus_adapter_timeout_cnt.sv
// BUSY-cycle watchdog: counts enabled cycles and flags the last allowed one.
module bus_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt <= '0;
        end else if (enable_i) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Asserted during the TIMEOUT_CYCLES-th enabled cycle so the abort lands on that edge.
    assign expired_o = enable_i && (cnt == LAST);

endmodule

// File: rtl/cpu_bus_adapter.sv
// Turns one CPU load/store request into one bus transaction and stalls until ack.
// Optional watchdog abort is enabled with the BUS_TIMEOUT_EN macro.
module cpu_bus_adapter
    import cpu_bus_adapter_pkg::*;
#(
    parameter int SEL_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              bus_err_o,
    output logic [31:0]       bus_addr_o,
    output logic [31:0]       bus_data_o,
    output logic              bus_we_o,
    output logic [SEL_W-1:0]  bus_select_o,
    input  logic [31:0]       bus_data_i,
    input  logic              bus_ack_i
);

    adp_state_e state, state_n;
    logic       accept;
    logic       timeout;

    wire unused_stall = ^{stall_i[5:STALL_MEM+1], stall_i[STALL_MEM-1:0]};

`ifdef BUS_TIMEOUT_EN
    bus_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (accept),
        .enable_i  (state == ADP_BUSY),
        .expired_o (timeout)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n     = state;
        cpu_stall_o = 1'b0;
        accept      = 1'b0;
        unique case (state)
            ADP_IDLE: begin
                cpu_stall_o = cpu_req_i && !flush_i;
                if (cpu_req_i && !flush_i) begin
                    accept  = 1'b1;
                    state_n = ADP_BUSY;
                end
            end
            ADP_BUSY: begin
                cpu_stall_o = !flush_i;
                if (flush_i)                   state_n = ADP_IDLE;
                else if (bus_ack_i || timeout) state_n = ADP_DONE;
            end
            ADP_DONE: begin
                if (flush_i || !stall_i[STALL_MEM]) state_n = ADP_IDLE;
            end
            default: state_n = ADP_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ADP_IDLE;
            cpu_rdata_o  <= ZERO_WORD;
            bus_err_o    <= 1'b0;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            bus_we_o     <= 1'b0;
            bus_select_o <= '0;
        end else begin
            state     <= state_n;
            bus_err_o <= 1'b0;
            if (accept) begin
                bus_addr_o   <= cpu_addr_i;
                bus_data_o   <= cpu_wdata_i;
                bus_we_o     <= cpu_we_i;
                bus_select_o <= SEL_W'(norm_sel(cpu_sel_i));
            end else if (state == ADP_BUSY) begin
                if (flush_i) begin
                    bus_select_o <= '0;
                    bus_we_o     <= 1'b0;
                end else if (bus_ack_i) begin
                    if (!bus_we_o) cpu_rdata_o <= bus_data_i;
                    bus_select_o <= '0;
                    bus_we_o     <= 1'b0;
                end else if (timeout) begin
                    cpu_rdata_o  <= ZERO_WORD;
                    bus_err_o    <= 1'b1;
                    bus_select_o <= '0;
                    bus_we_o     <= 1'b0;
                end
            end
        end
    end

endmodule
